// File: rtl/sdp_asym_pkg.sv
// Shared definitions for the asymmetric SDP RAM read-side line unpacker.
package sdp_asym_pkg;

  // Narrow words per wide RAM line, and the index width that selects one.
  localparam int unsigned LANES     = 4;
  localparam int unsigned LANE_BITS = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DRAIN,
    FINISH
  } state_t;

  // Wide line address holding a given narrow address (caller truncates to ABITS-2).
  function automatic logic [31:0] line_addr(input logic [31:0] narrow_addr);
    return narrow_addr >> LANE_BITS;
  endfunction

endpackage

// File: rtl/sdp_asym_line_unpacker_lane_serializer.sv
// Line buffer plus lane counter: presents one captured wide line as a
// lane-0-first narrow valid/ready stream.
module lane_serializer
  import sdp_asym_pkg::*;
#(
  parameter int unsigned DBITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [LANES*DBITS-1:0] rd,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [DBITS-1:0]       m_data,
  output logic                   last_lane
);

  logic [LANES*DBITS-1:0] line_buf;
  logic [LANE_BITS-1:0]   lane;
  logic                   valid;

  // Capture a new line on load; step through lanes on each accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_buf <= '0;
      lane     <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      line_buf <= rd;
      lane     <= '0;
      valid    <= 1'b1;
    end else if (valid && m_ready) begin
      lane <= lane + 1'b1;
      if (last_lane) valid <= 1'b0;
    end
  end

  // Lane select and final-lane flag.
  always_comb begin
    m_data    = line_buf[lane*DBITS +: DBITS];
    last_lane = (lane == LANE_BITS'(LANES - 1));
  end

  assign m_valid = valid;

endmodule

// File: rtl/sdp_asym_line_unpacker.sv
// Read-side stage for the asymmetric SDP RAM: issues wide line reads,
// captures each line, and streams it out as narrow words in address order.
module sdp_asym_line_unpacker
  import sdp_asym_pkg::*;
#(
  parameter int unsigned ABITS = 10,
  parameter int unsigned DBITS = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ABITS-3:0]     base_ra,
  input  logic [ABITS-2:0]     num_lines,
  output logic                 busy,
  output logic                 done,
  output logic [ABITS-3:0]     ra,
  input  logic [4*DBITS-1:0]   rd,
  output logic [DBITS-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);

  if (LANES != sdp_asym_pkg::LANES) begin : g_bad_lanes
    $error("sdp_asym_line_unpacker: LANES must be 4");
  end

  localparam logic [ABITS-2:0] REM_ONE = (ABITS-1)'(1);

  state_t           state, state_nx;
  logic [ABITS-2:0] remaining;
  logic             load;
  logic             last_lane;
  logic             line_end;

  // A line ends when its final lane is accepted downstream.
  assign line_end = m_valid && m_ready && last_lane;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and buffer load strobe.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (num_lines != '0) ? ISSUE : FINISH;
      end
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: begin
        load     = 1'b1;
        state_nx = DRAIN;
      end
      DRAIN: begin
        if (line_end) state_nx = (remaining > REM_ONE) ? ISSUE : FINISH;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Line address and remaining-line counter; ra wraps modulo the line count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra        <= '0;
      remaining <= '0;
    end else if (state == IDLE && start && num_lines != '0) begin
      ra        <= base_ra;
      remaining <= num_lines;
    end else if (state == DRAIN && line_end && remaining > REM_ONE) begin
      ra        <= ra + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  // Status decoded straight from the state register.
  always_comb begin
    busy   = (state == ISSUE) || (state == CAPTURE) || (state == DRAIN);
    done   = (state == FINISH);
    m_last = m_valid && last_lane && (remaining == REM_ONE);
  end

  lane_serializer #(
    .DBITS (DBITS)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .rd        (rd),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .last_lane (last_lane)
  );

endmodule

// File: tb/tb_sdp_asym_line_unpacker.sv
// Bench for sdp_asym_line_unpacker: behavioural RAM, table-driven bursts,
// reset-abort sequence and randomized bursts against a word-queue model.
module tb_sdp_asym_line_unpacker;

  localparam int ABITS = 10;
  localparam int DBITS = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ABITS-3:0] base_ra;
  logic [ABITS-2:0] num_lines;
  logic             busy, done;
  logic [ABITS-3:0] ra;
  logic [4*DBITS-1:0] rd;
  logic [DBITS-1:0] m_data;
  logic             m_valid, m_ready, m_last;

  logic [7:0] mem [1024];

  int n_cmp = 0;
  int n_err = 0;

  sdp_asym_line_unpacker #(
    .ABITS (ABITS),
    .DBITS (DBITS),
    .LANES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_ra   (base_ra),
    .num_lines (num_lines),
    .busy      (busy),
    .done      (done),
    .ra        (ra),
    .rd        (rd),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  // Registered wide read port of the RAM.
  always @(posedge clk)
    rd <= {mem[{ra, 2'd3}], mem[{ra, 2'd2}], mem[{ra, 2'd1}], mem[{ra, 2'd0}]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ready_val(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3) == 0;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  // Runs one burst; the expected word stream is built from RAM contents.
  task automatic run_burst(input int base, input int num, input int mode, input int restart_at,
                           output int done_cyc, output int fv_cyc, output int nwords,
                           output int first_w, output int last_w);
    logic [7:0] q[$];
    logic [7:0] prev_data;
    logic       prev_stall;
    logic       seen;
    int         total;
    int         limit;
    for (int l = 0; l < num; l++)
      for (int k = 0; k < 4; k++)
        q.push_back(mem[((base + l) % 256) * 4 + k]);
    total = q.size();
    nwords = 0; done_cyc = -1; fv_cyc = -1; first_w = 0; last_w = 0;
    prev_stall = 1'b0; prev_data = '0; seen = 1'b0;
    limit = 40 * num + 20;
    @(negedge clk);
    start = 1'b1; base_ra = 8'(base); num_lines = 9'(num);
    m_ready = ready_val(mode, 0);
    for (int c = 1; c <= limit && !seen; c++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      if (c == restart_at) begin
        start = 1'b1; base_ra = 8'(base + 77); num_lines = 9'd1;
      end
      m_ready = ready_val(mode, c);
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
      end
      if (m_valid && fv_cyc < 0) fv_cyc = c;
      if (done) begin seen = 1'b1; done_cyc = c; end
      check("busy", busy, num != 0 && !done);
      check("m_last", m_last, m_valid && q.size() == 1);
      if (m_valid && m_ready) begin
        if (q.size() > 0) check("m_data", m_data, q.pop_front());
        else              check("extra_word", nwords + 1, total);
        if (nwords == 0) first_w = m_data;
        last_w = m_data;
        nwords++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("word_count", nwords, total);
    @(negedge clk);
    check("done_pulse_len", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", m_valid, 0);
  endtask

  typedef struct {
    int base; int num; int mode; int restart;
    int cnt; int first; int last; int cyc; int fv; int ra;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int dc, fv, nw, fw, lw, dn;
    tbl[0] = '{0,   2,   0, 0, 8,    'h00, 'h07, 13,   3,  1};
    tbl[1] = '{0,   2,   1, 0, 8,    'h00, 'h07, -1,   3,  1};
    tbl[2] = '{255, 2,   0, 0, 8,    'hFC, 'h03, 13,   3,  0};
    tbl[3] = '{0,   0,   0, 0, 0,    0,    0,    1,    -1, 0};
    tbl[4] = '{0,   2,   0, 5, 8,    'h00, 'h07, 13,   3,  1};
    tbl[5] = '{10,  1,   2, 0, 4,    'h28, 'h2B, -1,   3,  10};
    tbl[6] = '{63,  3,   0, 0, 12,   'hFC, 'h07, 19,   3,  65};
    tbl[7] = '{100, 256, 0, 0, 1024, 'h90, 'h8F, 1537, 3,  99};

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    rst = 1'b0; start = 1'b0; base_ra = '0; num_lines = '0; m_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_ra", ra, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_burst(tbl[i].base, tbl[i].num, tbl[i].mode, tbl[i].restart, dc, fv, nw, fw, lw);
      check("tbl_count", nw, tbl[i].cnt);
      check("tbl_first", fw, tbl[i].first);
      check("tbl_last", lw, tbl[i].last);
      check("tbl_first_valid", fv, tbl[i].fv);
      check("tbl_ra_end", ra, tbl[i].ra);
      if (tbl[i].cyc >= 0) check("tbl_done_latency", dc, tbl[i].cyc);
    end

    // Reset while lane 2 of the first line is on the output.
    @(negedge clk);
    start = 1'b1; base_ra = 8'd5; num_lines = 9'd3; m_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_valid", m_valid, 1);
    check("pre_rst_data", m_data, 'h16);
    rst = 1'b1;
    #1;
    check("abort_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_last", m_last, 0);
    check("abort_ra", ra, 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (4) begin @(negedge clk); dn += int'(done); end
    check("abort_no_done", dn, 0);
    run_burst(20, 1, 0, 0, dc, fv, nw, fw, lw);
    check("restart_first", fw, 'h50);
    check("restart_last", lw, 'h53);
    check("restart_latency", dc, 7);

    // Randomized contents, bases, lengths and back-pressure.
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 25; t++) begin
      int b, n;
      b = int'($urandom_range(0, 255));
      n = int'($urandom_range(0, 5));
      run_burst(b, n, 2, 0, dc, fv, nw, fw, lw);
      if (n != 0) check("rand_ra_end", ra, (b + n - 1) % 256);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdp_asym_line_unpacker.md
Name: sdp_asym_line_unpacker

Overview:
- Downstream read-side stage for the asymmetric simple-dual-port block RAM: narrow writes of DBITS, wide reads of 4*DBITS per line.
- Issues wide-line read addresses to the RAM and captures each 4-lane line one cycle later.
- Serialises each line into a narrow DBITS valid/ready stream, lane 0 first, in ascending narrow-address order.
- Lets the RAM formal/sim harnesses read back narrow words written at narrow addresses.

Parameters:
ABITS, 10, narrow (write-side) address width; wide line address width is ABITS-2
DBITS, 8, narrow word width; RAM read data is 4*DBITS
LANES, 4, words per wide line; fixed at 4 (checked at elaboration)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a burst; sampled only in IDLE
base_ra  input  ABITS-2  first wide line address of the burst
num_lines  input  ABITS-1  number of wide lines to read, 0..2^(ABITS-2)
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the burst completes
ra  output  ABITS-2  wide read address to RAM (registered)
rd  input  4*DBITS  RAM registered read data; valid the cycle after ra is sampled
m_data  output  DBITS  narrow output word
m_valid  output  1  m_data valid
m_ready  input  1  downstream accept
m_last  output  1  high with the final word of the burst

Behaviour:
- Reset (async assert, sync release): state IDLE; ra=0, busy=0, done=0, m_valid=0, m_last=0, m_data=0, counters 0.
- FSM states: IDLE, ISSUE, CAPTURE, DRAIN, FINISH.
- IDLE, start=1, num_lines!=0:
  - Latch base_ra into ra and num_lines into remaining.
  - Set busy, then go to ISSUE.
- IDLE, start=1, num_lines=0:
  - Go to FINISH.
  - busy stays 0 and no words are emitted.
- ISSUE: ra is stable for one cycle; the RAM samples it at the closing edge. Go to CAPTURE.
- CAPTURE:
  - rd holds the line for ra.
  - At the closing edge, latch rd into the line buffer and set lane=0 and m_valid=1.
  - Go to DRAIN.
- DRAIN:
  - m_data = buffer lane[lane], i.e. bits lane*DBITS +: DBITS.
  - A transfer occurs when m_valid && m_ready. On transfer, lane increments.
  - Transfer on lane 3 with remaining>1:
    - Decrement remaining and set ra=ra+1, wrapping modulo 2^(ABITS-2).
    - Set m_valid=0 and go to ISSUE.
  - Transfer on lane 3 with remaining==1: set m_valid=0 and go to FINISH.
  - While m_ready=0: m_data, m_valid, m_last and lane stay stable. No data change while valid without a transfer.
- m_last = m_valid && lane==3 && remaining==1.
- FINISH: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Latency: start to first m_valid is 3 cycles (IDLE->ISSUE->CAPTURE->DRAIN). Per line with m_ready held high: 4 transfers plus 2 overhead cycles. Prefetch is not required.
- Boundary conditions:
  - start while busy is ignored.
  - num_lines=2^(ABITS-2) reads the whole RAM, wrapping back to base_ra-1.
  - ra wraps silently past the maximum line.
  - rst mid-burst aborts immediately: no done pulse, m_valid drops asynchronously.
- Concurrent writes to the RAM during a burst are outside this block. Read-during-write data is whatever the RAM returns.

Decomposition:
- Shared package sdp_asym_pkg:
  - State enum {IDLE, ISSUE, CAPTURE, DRAIN, FINISH}.
  - Constant LANES=4 and LANE_BITS=2.
  - Function line_addr(narrow_addr) returning narrow_addr[ABITS-1:2].
- Sub-module lane_serializer:
  - Holds the 4*DBITS buffer and 2-bit lane counter.
  - Ports: load, rd, m_ready, m_valid, m_data, last_lane.
  - The top FSM handles addressing and counting.

Test Plan:
- RAM preloaded so narrow address n holds n[7:0], DBITS=8. start, base_ra=0, num_lines=2, m_ready=1 -> m_data 00,01,02,03,04,05,06,07. First valid 3 cycles after start. m_last only on 07. done one cycle after the 07 transfer.
- Same burst with m_ready toggled 1,0,0,1,... -> identical word sequence, m_data stable while stalled, no duplicated or lost words.
- base_ra=255 (ABITS=10), num_lines=2 -> lines 255 then 0: words FC,FD,FE,FF,00,01,02,03. ra wraps to 0.
- num_lines=0 -> done pulses 1 cycle later, m_valid never asserts, busy stays 0.
- start pulsed again mid-burst -> ignored, sequence unchanged.
- rst asserted during DRAIN lane 2 -> m_valid=0 and busy=0 immediately, no done pulse. A subsequent start restarts cleanly from the new base_ra.
